// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO.
// Frames are start bit, LSB-first data, then stop bits; pending words go out back-to-back.
module fifo_uart_tx #(
   parameter int bits         = 8,
   parameter int clks_per_bit = 16,
   parameter int stop_bits    = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            pndng,
   input  logic [bits-1:0] Din,
   output logic            pop,
   output logic            tx,
   output logic            busy
);

   localparam int CW = $clog2(clks_per_bit);
   localparam int IW = (bits > 1) ? $clog2(bits) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(clks_per_bit - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(bits - 1);
   localparam logic          STOP_LAST = (stop_bits == 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            stop_q, stop_d;
   logic [bits-1:0] shreg_q, shreg_d;
   logic [bits-1:0] shifted;
   logic            tx_q, tx_d;
   logic            pop_q, pop_d;
   logic            busy_q, busy_d;
   logic            bitDone;
   logic            startOk;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      pop_d   = 1'b0;
      busy_d  = busy_q;
      bitDone = (cnt_q == CNT_LAST);
      startOk = en && pndng;
      shifted = shreg_q >> 1;

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            cnt_d  = '0;
            if (startOk) begin
               shreg_d = Din;
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               pop_d   = 1'b1;
               idx_d   = '0;
               stop_d  = 1'b0;
            end
         end
         START: begin
            cnt_d = cnt_q + 1'b1;
            if (bitDone) begin
               cnt_d   = '0;
               state_d = DATA;
               tx_d    = shreg_q[0];
            end
         end
         DATA: begin
            cnt_d = cnt_q + 1'b1;
            if (bitDone) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
                  stop_d  = 1'b0;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  shreg_d = shifted;
                  tx_d    = shifted[0];
               end
            end
         end
         STOP: begin
            cnt_d = cnt_q + 1'b1;
            if (bitDone) begin
               cnt_d = '0;
               if (stop_q != STOP_LAST) begin
                  stop_d = 1'b1;
               end else if (startOk) begin
                  // Next word launches on the last stop edge so there is no idle gap
                  shreg_d = Din;
                  state_d = START;
                  tx_d    = 1'b0;
                  pop_d   = 1'b1;
                  idx_d   = '0;
                  stop_d  = 1'b0;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         pop_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         pop_q   <= pop_d;
         busy_q  <= busy_d;
      end
   end

   assign pop  = pop_q;
   assign tx   = tx_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: two transmitters (one and two stop bits) fed from queue-modelled FIFOs,
// compared every cycle against a frame-offset model of the serial line.
module tb_fifo_uart_tx;

   localparam int BITS = 8;
   localparam int CPB  = 4;
   localparam int LEN1 = (1 + BITS + 1) * CPB;
   localparam int LEN2 = (1 + BITS + 2) * CPB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, pndng, en2, pndng2;
   logic [7:0] Din, Din2;
   logic       pop, tx, busy, pop2, tx2, busy2;

   fifo_uart_tx #(.bits(BITS), .clks_per_bit(CPB), .stop_bits(1)) dut (
      .clk(clk), .rst(rst), .en(en), .pndng(pndng), .Din(Din),
      .pop(pop), .tx(tx), .busy(busy)
   );

   fifo_uart_tx #(.bits(BITS), .clks_per_bit(CPB), .stop_bits(2)) dut2 (
      .clk(clk), .rst(rst), .en(en2), .pndng(pndng2), .Din(Din2),
      .pop(pop2), .tx(tx2), .busy(busy2)
   );

   logic [7:0] q1[$];
   logic [7:0] q2[$];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // Reference: a frame is active for plen cycles; off is the cycle offset inside it
   bit         act[2];
   int         off[2];
   logic [7:0] wrd[2];
   int         plen[2];

   int popCnt[2], busyCnt[2], lastPop[2], popGap[2];
   int lowRun, maxLowRun;

   function automatic logic lineLevel(logic [7:0] w, int k);
      if (k < CPB) return 1'b0;
      if (k < (1 + BITS) * CPB) return w[k / CPB - 1];
      return 1'b1;
   endfunction

   function automatic logic expTx(int i);
      return act[i] ? lineLevel(wrd[i], off[i]) : 1'b1;
   endfunction

   function automatic logic expPop(int i);
      return act[i] && (off[i] == 0);
   endfunction

   function automatic void advance(int i, logic r, logic e, logic n, logic [7:0] h);
      if (r) begin
         act[i] = 1'b0;
      end else if (act[i] && off[i] < plen[i] - 1) begin
         off[i] = off[i] + 1;
      end else if (e && n) begin
         act[i] = 1'b1;
         off[i] = 0;
         wrd[i] = h;
      end else begin
         act[i] = 1'b0;
      end
   endfunction

   task automatic checkBit(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s cycle %0d observed %b expected %b", tag, cycle, obs, exp);
      end
   endtask

   task automatic checkVal(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s cycle %0d observed %0d expected %0d", tag, cycle, obs, exp);
      end
   endtask

   task automatic refreshInputs();
      pndng  = (q1.size() > 0);
      Din    = pndng ? q1[0] : 8'($urandom);
      pndng2 = (q2.size() > 0);
      Din2   = pndng2 ? q2[0] : 8'($urandom);
   endtask

   task automatic clearStats();
      for (int i = 0; i < 2; i++) begin
         popCnt[i]  = 0;
         busyCnt[i] = 0;
         lastPop[i] = -1;
         popGap[i]  = 0;
      end
      lowRun    = 0;
      maxLowRun = 0;
   endtask

   task automatic step();
      logic       p0, p1, r, e0, e1, n0, n1;
      logic [7:0] h0, h1;
      p0 = pop;  p1 = pop2;  r = rst;
      e0 = en;   e1 = en2;   n0 = pndng;  n1 = pndng2;
      h0 = Din;  h1 = Din2;
      @(posedge clk);
      #1;
      cycle++;
      if (p0 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
      if (p1 === 1'b1 && q2.size() > 0) void'(q2.pop_front());
      refreshInputs();
      advance(0, r, e0, n0, h0);
      advance(1, r, e1, n1, h1);
      checkBit("tx",    tx,    expTx(0));
      checkBit("busy",  busy,  act[0]);
      checkBit("pop",   pop,   expPop(0));
      checkBit("tx2",   tx2,   expTx(1));
      checkBit("busy2", busy2, act[1]);
      checkBit("pop2",  pop2,  expPop(1));
      if (pop === 1'b1) begin
         popCnt[0]++;
         if (lastPop[0] >= 0) popGap[0] = cycle - lastPop[0];
         lastPop[0] = cycle;
      end
      if (pop2 === 1'b1) begin
         popCnt[1]++;
         if (lastPop[1] >= 0) popGap[1] = cycle - lastPop[1];
         lastPop[1] = cycle;
      end
      if (busy === 1'b1) busyCnt[0]++;
      if (busy2 === 1'b1) busyCnt[1]++;
      if (tx === 1'b0) begin
         lowRun++;
         if (lowRun > maxLowRun) maxLowRun = lowRun;
      end else begin
         lowRun = 0;
      end
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic applyStimulus();
      logic [7:0] w;
      // Reset held with a word waiting; first frame launches right after release
      rst = 1'b1; en = 1'b1; en2 = 1'b0;
      q1.push_back(8'h5A);
      refreshInputs();
      clearStats();
      run(3);
      rst = 1'b0;
      run(44);
      checkVal("resetFramePops", popCnt[0], 1);

      // Single word 0xA5
      clearStats();
      q1.push_back(8'hA5);
      refreshInputs();
      run(46);
      checkVal("singlePops", popCnt[0], 1);
      checkVal("singleBusy", busyCnt[0], LEN1);

      // Back-to-back 0x00 then 0xFF
      clearStats();
      q1.push_back(8'h00);
      q1.push_back(8'hFF);
      refreshInputs();
      run(90);
      checkVal("b2bPops", popCnt[0], 2);
      checkVal("b2bGap", popGap[0], LEN1);
      checkVal("b2bLowRun", maxLowRun, 36);

      // Enable gating, then en dropped ten cycles into a frame
      clearStats();
      en = 1'b0;
      w = 8'($urandom);
      q1.push_back(w);
      w = 8'($urandom);
      q1.push_back(w);
      refreshInputs();
      run(100);
      checkVal("gatedPops", popCnt[0], 0);
      en = 1'b1;
      for (int i = 0; i < 5 && popCnt[0] == 0; i++) step();
      checkVal("gatedStart", popCnt[0], 1);
      run(9);
      en = 1'b0;
      run(45);
      checkVal("gatedOnePop", popCnt[0], 1);
      checkVal("gatedBusy", busyCnt[0], LEN1);

      // Reset during data bit 3; next word goes out after release
      w = 8'($urandom);
      q1.push_back(w);
      refreshInputs();
      clearStats();
      en = 1'b1;
      for (int i = 0; i < 5 && popCnt[0] == 0; i++) step();
      checkVal("abortStart", popCnt[0], 1);
      run(17);
      rst = 1'b1;
      step();
      checkBit("abortTx", tx, 1'b1);
      checkBit("abortBusy", busy, 1'b0);
      rst = 1'b0;
      clearStats();
      run(50);
      checkVal("abortPops", popCnt[0], 1);
      checkVal("abortBusyCnt", busyCnt[0], LEN1);
      checkVal("abortDrained", q1.size(), 0);

      // Two stop bits, back-to-back
      en = 1'b0;
      en2 = 1'b1;
      clearStats();
      q2.push_back(8'h3C);
      w = 8'($urandom);
      q2.push_back(w);
      refreshInputs();
      run(100);
      checkVal("stop2Pops", popCnt[1], 2);
      checkVal("stop2Gap", popGap[1], LEN2);
      checkVal("stop2Busy", busyCnt[1], 2 * LEN2);

      // Random traffic, enables and occasional reset
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 47) == 0) begin
            w = 8'($urandom);
            q1.push_back(w);
         end
         if ($urandom_range(0, 47) == 0) begin
            w = 8'($urandom);
            q2.push_back(w);
         end
         en  = ($urandom_range(0, 9) != 0);
         en2 = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 249) == 0);
         refreshInputs();
         step();
      end
      rst = 1'b0;
      en  = 1'b1;
      en2 = 1'b1;
      run(800);
   endtask

   task automatic checkOutput();
      checkVal("drain1", q1.size(), 0);
      checkVal("drain2", q2.size(), 0);
      checkBit("idleTx", tx, 1'b1);
      checkBit("idleTx2", tx2, 1'b1);
   endtask

   initial begin
      plen[0] = LEN1;
      plen[1] = LEN2;
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0;
         off[i] = 0;
         wrd[i] = '0;
      end
      applyStimulus();
      checkOutput();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
